reg_piso_reader: RTL and testbench

Parallel-in, serial-out reader for an N-bit register value. It captures a parallel word on a load handshake and presents it one bit at a time on a paced serial output. It signals busy while shifting and pulses done once the last bit has been consumed. It sits downstream of the team's chip-enable register blocks and drives serial readback, debug taps and bit-serial links.

---
 rtl/reg_piso_reader.sv | 141 ++++++++++++++
 tb/tb_reg_piso_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_piso_reader.sv
// -----------------------------------------------------------------------------
// reg_piso_reader
//
// Parallel-in, serial-out reader. A word presented on i_d is captured when
// i_load is seen while the block is idle. The word is then presented one bit
// at a time on o_sdo. Each bit stays on o_sdo until the consumer strobes
// i_shift_en. After the last bit has been consumed, o_done pulses for one
// cycle and the block returns to idle.
//
// Parameters
//   WIDTH       word length in bits (>= 2)
//   MSB_FIRST   1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_LEVEL  level on o_sdo whenever no bit is being presented
//
// Ports
//   i_clk       clock, rising edge active
//   i_rst_n     asynchronous active-low reset
//   i_d         parallel word to read out
//   i_load      load request, accepted only while o_ready=1
//   o_ready     idle and able to accept i_load
//   i_shift_en  consumer strobe; the bit on o_sdo is consumed when o_svalid=1
//   o_sdo       serial data bit
//   o_svalid    o_sdo carries a valid data bit
//   o_busy      a word is in flight
//   o_done      one-cycle pulse after the final bit is consumed
//
// Every output is decoded from registered state only, so no combinational
// path runs from any input to any output.
// -----------------------------------------------------------------------------
module reg_piso_reader #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_load,
    output logic             o_ready,
    input  logic             i_shift_en,
    output logic             o_sdo,
    output logic             o_svalid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_consume;

    // LOAD is acted on only while idle. Because of this, a LOAD that arrives
    // on the same edge as the last SHIFT_EN is ignored and is not queued.
    assign w_accept  = (r_state == S_IDLE) && i_load;
    assign w_consume = (r_state == S_SHIFT) && i_shift_en;

    // State register
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that were present before the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: shift register and bit counter
    // NOTE: the shift register is a plain register and not a memory array, so
    // it is cleared by reset together with the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shreg <= i_d;
            r_cnt   <= '0;
        end else if (w_consume) begin
            if (MSB_FIRST) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end else begin
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
            end
            // The counter holds at LAST on the final bit so it never wraps
            // inside a word. The next accepted load clears it.
            if (r_cnt != LAST) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Next-state logic
    // NOTE: every signal assigned in a combinational block gets a default
    // first. Without one, synthesis infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_load) w_next = S_SHIFT;
            S_SHIFT: if (i_shift_en && (r_cnt == LAST)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode (registered state only)
    always_comb begin
        o_ready  = 1'b0;
        o_svalid = 1'b0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_sdo    = IDLE_LEVEL;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
            end
            S_SHIFT: begin
                o_svalid = 1'b1;
                o_busy   = 1'b1;
                o_sdo    = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_piso_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_piso_reader
//
// Two instances share one stimulus stream:
//   u_msb : MSB_FIRST=1, IDLE_LEVEL=0
//   u_lsb : MSB_FIRST=0, IDLE_LEVEL=1
// A reference model sees every accepted load and pushes the expected bit
// stream of each instance into its own queue. A monitor running on the
// falling edge compares the presented bits and handshake flags against those
// queues. The directed sections also compare the reassembled words and the
// DONE/READY cycle positions against fixed values.
// -----------------------------------------------------------------------------
module tb_reg_piso_reader;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] i_d;
    logic             i_load;
    logic             i_shift_en;

    logic o_ready_m, o_sdo_m, o_svalid_m, o_busy_m, o_done_m;
    logic o_ready_l, o_sdo_l, o_svalid_l, o_busy_l, o_done_l;

    reg_piso_reader #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_d        (i_d),
        .i_load     (i_load),
        .o_ready    (o_ready_m),
        .i_shift_en (i_shift_en),
        .o_sdo      (o_sdo_m),
        .o_svalid   (o_svalid_m),
        .o_busy     (o_busy_m),
        .o_done     (o_done_m)
    );

    reg_piso_reader #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_d        (i_d),
        .i_load     (i_load),
        .o_ready    (o_ready_l),
        .i_shift_en (i_shift_en),
        .o_sdo      (o_sdo_l),
        .o_svalid   (o_svalid_l),
        .o_busy     (o_busy_l),
        .o_done     (o_done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // m_left counts the bits of the current word that have not been consumed
    // yet. m_done marks the single cycle after the last bit was consumed.
    int   m_left = 0;
    bit   m_done = 1'b0;
    logic exp_m[$];
    logic exp_l[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            exp_m.delete();
            exp_l.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (i_shift_en) begin
                m_left = m_left - 1;
                m_done = (m_left == 0);
            end
        end else if (i_load) begin
            m_left = WIDTH;
            for (int k = 0; k < WIDTH; k++) begin
                exp_m.push_back(i_d[WIDTH-1-k]);
                exp_l.push_back(i_d[k]);
            end
        end
    end

    // -------------------------------------------------------------- monitor
    logic [WIDTH-1:0] got_m;
    logic [WIDTH-1:0] got_l;

    task automatic check_flags(input string tag, input logic rdy, input logic sv,
                               input logic bsy, input logic dn);
        check({tag, "_ready"},  rdy, (m_left == 0) && !m_done);
        check({tag, "_svalid"}, sv,  m_left > 0);
        check({tag, "_busy"},   bsy, m_left > 0);
        check({tag, "_done"},   dn,  m_done);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_flags("mon_m", o_ready_m, o_svalid_m, o_busy_m, o_done_m);
            check_flags("mon_l", o_ready_l, o_svalid_l, o_busy_l, o_done_l);
            if (o_svalid_m) begin
                if (exp_m.size() == 0) begin
                    check("mon_m_unexpected_bit", 1, 0);
                end else begin
                    check("mon_m_sdo", o_sdo_m, exp_m[0]);
                    if (i_shift_en) begin
                        void'(exp_m.pop_front());
                        got_m = {got_m[WIDTH-2:0], o_sdo_m};
                    end
                end
            end else begin
                check("mon_m_sdo_idle", o_sdo_m, 1'b0);
            end
            if (o_svalid_l) begin
                if (exp_l.size() == 0) begin
                    check("mon_l_unexpected_bit", 1, 0);
                end else begin
                    check("mon_l_sdo", o_sdo_l, exp_l[0]);
                    if (i_shift_en) begin
                        void'(exp_l.pop_front());
                        got_l = {o_sdo_l, got_l[WIDTH-1:1]};
                    end
                end
            end else begin
                check("mon_l_sdo_idle", o_sdo_l, 1'b1);
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready_m"},  o_ready_m,  1'b1);
        check({tag, "_svalid_m"}, o_svalid_m, 1'b0);
        check({tag, "_busy_m"},   o_busy_m,   1'b0);
        check({tag, "_done_m"},   o_done_m,   1'b0);
        check({tag, "_sdo_m"},    o_sdo_m,    1'b0);
        check({tag, "_ready_l"},  o_ready_l,  1'b1);
        check({tag, "_svalid_l"}, o_svalid_l, 1'b0);
        check({tag, "_busy_l"},   o_busy_l,   1'b0);
        check({tag, "_done_l"},   o_done_l,   1'b0);
        check({tag, "_sdo_l"},    o_sdo_l,    1'b1);
    endtask

    // Reset asserted mid-cycle; the outputs must be at reset values at once.
    // Call this from a point 1 ns after a rising edge.
    task automatic mid_cycle_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals({tag, "_now"});
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_vals({tag, "_held"});
        end
        #2;
        rst_n = 1'b1;
    endtask

    // Loads d while idle, then drives en_pat[c] on SHIFT_EN during cycle t+c.
    // DONE is expected in cycle t+done_at and READY one cycle later.
    task automatic run_word(input string tag, input logic [WIDTH-1:0] d,
                            input logic [15:0] en_pat, input int done_at);
        check({tag, "_pre_ready"}, o_ready_m, 1'b1);
        got_m = '0;
        got_l = '0;
        i_d        = d;
        i_load     = 1'b1;
        i_shift_en = 1'b1;
        tick();
        i_load = 1'b0;
        i_d    = ~d;
        for (int c = 0; c < done_at; c++) begin
            i_shift_en = en_pat[c];
            tick();
        end
        check({tag, "_done_m"}, o_done_m, 1'b1);
        check({tag, "_done_l"}, o_done_l, 1'b1);
        i_shift_en = 1'b0;
        tick();
        check({tag, "_ready_m"}, o_ready_m, 1'b1);
        check({tag, "_ready_l"}, o_ready_l, 1'b1);
        check({tag, "_done_gone"}, o_done_m, 1'b0);
        check({tag, "_word_m"}, got_m, d);
        check({tag, "_word_l"}, got_l, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        i_d        = '0;
        i_load     = 1'b0;
        i_shift_en = 1'b0;
        got_m      = '0;
        got_l      = '0;
        #1;
        check_reset_vals("por");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check_reset_vals("idle");

        // MSB-first readout, and the LSB-first instance sees the same word.
        run_word("a5_cont", 8'hA5, 16'hFFFF, 8);
        // LSB-first readout.
        run_word("3c_cont", 8'h3C, 16'hFFFF, 8);
        // Stalls: three cycles after bit 2 and one after bit 6.
        run_word("f0_stall", 8'hF0, 16'h1BC7, 12);

        // Reset mid-word after four bits have been consumed.
        got_m      = '0;
        i_d        = 8'hFF;
        i_load     = 1'b1;
        i_shift_en = 1'b1;
        tick();
        i_load = 1'b0;
        repeat (4) tick();
        check("rstmid_busy_before", o_busy_m, 1'b1);
        mid_cycle_reset("rstmid");
        i_shift_en = 1'b0;
        tick();
        check_reset_vals("rstmid_after");
        run_word("01_after_rst", 8'h01, 16'hFFFF, 8);

        // Busy rejection: LOAD is held high through SHIFT and DONE.
        got_m      = '0;
        got_l      = '0;
        i_d        = 8'h81;
        i_load     = 1'b1;
        i_shift_en = 1'b1;
        tick();
        i_d = 8'h7E;
        for (int c = 0; c <= WIDTH; c++) begin
            check("busy_ready_low", o_ready_m, 1'b0);
            tick();
        end
        check("busy_word_m", got_m, 8'h81);
        check("busy_word_l", got_l, 8'h81);
        check("busy_ready_back", o_ready_m, 1'b1);
        i_load = 1'b0;
        run_word("7e_after_busy", 8'h7E, 16'hFFFF, 8);

        // Randomised traffic with occasional mid-cycle resets.
        for (int n = 0; n < 4000; n++) begin
            i_d        = WIDTH'($urandom);
            i_load     = ($urandom_range(0, 3) == 0);
            i_shift_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                mid_cycle_reset("rand_rst");
            end
            tick();
        end

        // Drain whatever word is still in flight.
        i_load     = 1'b0;
        i_shift_en = 1'b1;
        repeat (WIDTH + 4) tick();
        check("drain_exp_m_empty", exp_m.size(), 0);
        check("drain_exp_l_empty", exp_l.size(), 0);
        check("drain_ready", o_ready_m, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
